cpu_datapath: RTL

Register file, ALU, program counter and memory ports of the CPU, driven by the control unit's decoded outputs. It fetches the instruction word for the control unit and returns the A/D/M register values and ALU flags the control unit consumes. It executes the A/D/M writes, data-memory stores and PC updates the control unit requests. It runs a free 4-phase sequencer that stays in lockstep with the control unit's FETCH/DECODE/EXECUTE/STORE FSM because both leave reset together.

---
 rtl/cpu_datapath.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_datapath.sv
// cpu_datapath: register file (A/D/M), ALU, program counter and memory ports.
// A free-running 4-phase sequencer (FETCH/DECODE/EXECUTE/STORE) runs in
// lockstep with the control unit's FSM because both leave reset together.
module cpu_datapath #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [1:0]  phase,
    output logic [15:0] pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic [15:0] reg_a_out,
    output logic [15:0] reg_d_out,
    output logic [15:0] reg_m_out,
    output logic        is_negative,
    output logic        is_zero,
    input  logic        instr_type,
    input  logic [15:0] addr_in,
    input  logic        reg_a_en,
    input  logic        reg_d_en,
    input  logic        reg_m_en,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [1:0]  opcode,
    input  logic        negate_output,
    input  logic        zero_x,
    input  logic        zero_y,
    input  logic        set_pc,
    output logic [15:0] dmem_addr,
    input  logic [15:0] dmem_rdata,
    output logic [15:0] dmem_wdata,
    output logic        dmem_we
);

    localparam logic [1:0] PH_FETCH   = 2'd0;
    localparam logic [1:0] PH_DECODE  = 2'd1;
    localparam logic [1:0] PH_EXECUTE = 2'd2;
    localparam logic [1:0] PH_STORE   = 2'd3;

    // ALU: operand zeroing, one of four operations, optional bitwise inversion.
    function automatic logic [15:0] alu_fn(
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [1:0]  op,
        input logic        zx,
        input logic        zy,
        input logic        neg
    );
        logic [15:0] aa;
        logic [15:0] bb;
        logic [15:0] r;
        aa = zx ? 16'h0000 : a;
        bb = zy ? 16'h0000 : b;
        case (op)
            2'd0:    r = aa + bb;
            2'd1:    r = aa & bb;
            2'd2:    r = aa | bb;
            2'd3:    r = aa ^ bb;
            default: r = aa + bb;
        endcase
        return neg ? ~r : r;
    endfunction

    logic [1:0]  phase_q, phase_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [15:0] m_q, m_d;
    logic        neg_q, neg_d;
    logic        zero_q, zero_d;
    logic        dmem_we_q, dmem_we_d;
    logic [15:0] dmem_wdata_q, dmem_wdata_d;
    logic        jump_q, jump_d;
    logic [15:0] jump_tgt_q, jump_tgt_d;
    logic [15:0] alu_q, alu_d;
    logic [15:0] alu_res_s;

    // Combinational ALU result, consumed at the end of EXECUTE.
    always_comb begin
        alu_res_s = alu_fn(x, y, opcode, zero_x, zero_y, negate_output);
    end

    // Phase sequencer next state: free-running 0->1->2->3->0, no stall.
    always_comb begin
        phase_d = phase_q + 2'd1;
    end

    // Datapath next state, selected by the current phase.
    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        a_d          = a_q;
        d_d          = d_q;
        m_d          = m_q;
        neg_d        = neg_q;
        zero_d       = zero_q;
        dmem_we_d    = dmem_we_q;
        dmem_wdata_d = dmem_wdata_q;
        jump_d       = jump_q;
        jump_tgt_d   = jump_tgt_q;
        alu_d        = alu_q;
        case (phase_q)
            PH_FETCH: begin
                instr_d = imem_data;
                m_d     = dmem_rdata;
            end
            PH_DECODE: begin
                // Jump target is A as seen by this instruction's decode.
                jump_d     = set_pc;
                jump_tgt_d = a_q;
            end
            PH_EXECUTE: begin
                alu_d        = alu_res_s;
                neg_d        = alu_res_s[15];
                zero_d       = (alu_res_s == 16'h0000);
                dmem_we_d    = reg_m_en & ~instr_type;
                dmem_wdata_d = alu_res_s;
            end
            PH_STORE: begin
                // The store in this phase still addresses the old A.
                if (instr_type) begin
                    a_d = addr_in;
                end else begin
                    if (reg_a_en) begin
                        a_d = alu_q;
                    end else begin
                        a_d = a_q;
                    end
                    if (reg_d_en) begin
                        d_d = alu_q;
                    end else begin
                        d_d = d_q;
                    end
                end
                pc_d      = jump_q ? jump_tgt_q : (pc_q + 16'd1);
                dmem_we_d = 1'b0;
            end
            default: begin
                dmem_we_d = 1'b0;
            end
        endcase
    end

    // State register: synchronous reset cancels any pending store.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= PH_FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= 16'h0000;
            a_q          <= 16'h0000;
            d_q          <= 16'h0000;
            m_q          <= 16'h0000;
            neg_q        <= 1'b0;
            zero_q       <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_wdata_q <= 16'h0000;
            jump_q       <= 1'b0;
            jump_tgt_q   <= 16'h0000;
            alu_q        <= 16'h0000;
        end else begin
            phase_q      <= phase_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            a_q          <= a_d;
            d_q          <= d_d;
            m_q          <= m_d;
            neg_q        <= neg_d;
            zero_q       <= zero_d;
            dmem_we_q    <= dmem_we_d;
            dmem_wdata_q <= dmem_wdata_d;
            jump_q       <= jump_d;
            jump_tgt_q   <= jump_tgt_d;
            alu_q        <= alu_d;
        end
    end

    // Outputs are driven straight from registers.
    always_comb begin
        phase       = phase_q;
        pc          = pc_q;
        imem_addr   = pc_q;
        instr       = instr_q;
        reg_a_out   = a_q;
        reg_d_out   = d_q;
        reg_m_out   = m_q;
        is_negative = neg_q;
        is_zero     = zero_q;
        dmem_addr   = a_q;
        dmem_wdata  = dmem_wdata_q;
        dmem_we     = dmem_we_q;
    end

endmodule
